sram_sp_bwe_model: RTL and testbench
====================================

Name: sram_sp_bwe_model

Overview:
Parametrised behavioural model of a single-port synchronous SRAM macro. It is the successor to the fixed 128-entry, single-latency macro models. It adds per-segment write masking, a configurable read pipeline, a read-valid strobe and a post-reset zero-fill sweep. It sits under the cache/TLB SRAM wrappers in simulation and FPGA builds, in place of foundry macros.

Parameters:
DATA_WIDTH, 64, bits per word
DEPTH, 128, number of words; need not be a power of two
ADDR_WIDTH, 7, address width; must satisfy 2**ADDR_WIDTH >= DEPTH
SEG_WIDTH, 8, bits per write-mask segment; DATA_WIDTH must be a multiple of SEG_WIDTH
READ_LATENCY, 1, cycles from read request to Q valid; legal range 1..4

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous, active-high reset
CEB  input  1  chip enable, active-low
WEB  input  1  write enable, active-low; 1 = read when CEB=0
A  input  ADDR_WIDTH  word address
D  input  DATA_WIDTH  write data
BWEB  input  DATA_WIDTH/SEG_WIDTH  per-segment write enable, active-low
Q  output  DATA_WIDTH  read data
Q_VALID  output  1  high in the cycle Q carries read data
INIT_DONE  output  1  high once the zero-fill sweep has completed

Behaviour:
- Reset (RST=1 at posedge):
  - Q=0, Q_VALID=0, INIT_DONE=0.
  - Read pipeline flushed.
  - FSM enters INIT with sweep pointer 0.
  - Array contents are not cleared by reset itself; the sweep clears them.
- FSM states:
  - INIT: writes 0 to ram[ptr] each cycle and increments ptr. When ptr=DEPTH-1 is written, go to READY on the next cycle and set INIT_DONE=1.
  - Sweep duration: exactly DEPTH cycles after RST deasserts.
  - READY: normal operation. Stays in READY until RST.
- In INIT, all CEB/WEB requests are ignored: no write and no Q_VALID.
- RST asserted mid-sweep restarts the sweep at ptr 0.
- Write (READY, CEB=0, WEB=0):
  - For each segment i with BWEB[i]=0, ram[A][i*SEG_WIDTH +: SEG_WIDTH] <= D segment; segments with BWEB[i]=1 are unchanged.
  - Visible to a read issued on the next cycle.
  - No Q_VALID is produced.
- Read (READY, CEB=0, WEB=1):
  - Array sampled at the request edge.
  - Q and Q_VALID update READ_LATENCY posedges later; Q_VALID is high for exactly one cycle per request.
  - Back-to-back reads every cycle are fully pipelined, giving a throughput of 1/cycle.
- Address A >= DEPTH: writes are dropped; reads return 0 with Q_VALID=1.
- Idle or write cycles: Q_VALID=0 and Q holds its last value (default build).
- BWEB is ignored on reads and when CEB=1.
- Pipeline: READ_LATENCY stages, each holding {valid, data}. Q is driven from the last stage's data only when that stage is valid, otherwise held.

Optional Feature:
SRAM_RANDOMIZE_Q_EN
- Defined: in every cycle where Q_VALID=0, Q is driven with fresh $random-derived data (concatenate enough 32-bit $random words to fill DATA_WIDTH). This exposes consumers that sample Q without a valid read. The initial array contents are also randomized before the sweep.
- Undefined: Q holds its last value as above; the array starts at X before the sweep.

Decomposition:
- Shared package sram_model_pkg holds:
  - the READ_LATENCY limits (1..4);
  - the FSM state typedef (INIT, READY);
  - a function computing the segment count DATA_WIDTH/SEG_WIDTH.
- One natural sub-module: sram_rd_pipe, a parametrised READ_LATENCY-stage valid+data shift pipeline with synchronous flush, instantiated for the read path.

Test Plan:
- Sweep: DEPTH=128, RST high 2 cycles then low → INIT_DONE rises exactly 128 cycles later. Reading every address afterwards returns 0 with Q_VALID=1 each.
- Masked write: write A=5, D=64'h1122334455667788, BWEB=8'h00; then write A=5, D=64'hFFFFFFFFFFFFFFFF, BWEB=8'hF0; read A=5 → Q=64'h11223344FFFFFFFF.
- Latency: READ_LATENCY=3, reads to A=0..3 on 4 consecutive cycles after prior writes of 10..13 → Q=10,11,12,13 on cycles 3..6 after the first request, with Q_VALID high for exactly those 4 cycles.
- Requests during INIT: CEB=0, WEB=0, A=7, D=all-ones issued 5 cycles after reset → ignored. After INIT_DONE, read A=7 → 0.
- Reset mid-sweep and mid-read:
  - RST pulsed at sweep cycle 60 → INIT_DONE rises 128 cycles after the second deassertion.
  - RST asserted while a READ_LATENCY=2 read is in flight → Q_VALID never asserts for that read, and Q=0.
- Out-of-range address: DEPTH=100, ADDR_WIDTH=7, write A=110 with D=all-ones, then read A=110 → Q=0 with Q_VALID=1, and ram[0..99] unchanged.

Source files
------------

// File: rtl/sram_model_pkg.sv
// Shared definitions for the SRAM behavioural models.
// Holds read-latency limits, FSM state encoding and a segment-count helper.
package sram_model_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_READY = 1'b1;

    function automatic int seg_count(input int dw, input int sw);
        return dw / sw;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Valid+data shift pipeline for the SRAM read path, STAGES deep.
// Ports: i_clk, i_flush (sync clear), i_valid/i_data in, o_valid/o_data out.
module sram_rd_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_dat [STAGES];

    // Data only advances behind a valid token, so every stage
    // (and therefore the output) holds its last payload when idle.
    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_dat[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_dat[s] <= r_dat[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[STAGES-1];
    assign o_data  = r_dat[STAGES-1];

endmodule

// File: rtl/sram_sp_bwe_model.sv
// Single-port synchronous SRAM model: per-segment write mask, READ_LATENCY
// read pipeline, read-valid strobe and a zero-fill sweep after reset.
// Ports: CLK, RST (sync, active-high), CEB/WEB (active-low), A, D,
//        BWEB (active-low per segment), Q, Q_VALID, INIT_DONE.
// Option: define SRAM_RANDOMIZE_Q_EN to drive random Q when Q_VALID=0
//         and to start the array from random contents.
module sram_sp_bwe_model
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 128,
    parameter int ADDR_WIDTH   = 7,
    parameter int SEG_WIDTH    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CEB,
    input  logic                   WEB,
    input  logic [ADDR_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  D,
    input  logic [seg_count(DATA_WIDTH, SEG_WIDTH)-1:0] BWEB,
    output logic [DATA_WIDTH-1:0]  Q,
    output logic                   Q_VALID,
    output logic                   INIT_DONE
);

    localparam int NSEG = seg_count(DATA_WIDTH, SEG_WIDTH);

    // Out-of-range latencies are pinned to the nearest legal value.
    localparam int LAT =
        (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
        (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX :
        READ_LATENCY;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_init_done;

    logic                  w_in_range;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_pipe_vld;
    logic [DATA_WIDTH-1:0] w_pipe_dat;

    // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign w_in_range =
        ({1'b0, A} < (ADDR_WIDTH + 1)'(DEPTH));

    assign w_req = (r_state == ST_READY) && !CEB;
    assign w_wr  = w_req && !WEB && w_in_range;
    assign w_rd  = w_req && WEB;

    assign w_rd_data = w_in_range ? r_mem[A] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == LAST_ADDR) begin
                r_state     <= ST_READY;
                r_init_done <= 1'b1;
            end
        end
    end

    // Array has no reset; the sweep is what clears it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == ST_INIT) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr) begin
                for (int s = 0; s < NSEG; s++) begin
                    if (!BWEB[s]) begin
                        r_mem[A][s*SEG_WIDTH +: SEG_WIDTH] <=
                            D[s*SEG_WIDTH +: SEG_WIDTH];
                    end
                end
            end
        end
    end

    sram_rd_pipe #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (LAT)
    ) u_rd_pipe (
        .i_clk   (CLK),
        .i_flush (RST),
        .i_valid (w_rd),
        .i_data  (w_rd_data),
        .o_valid (w_pipe_vld),
        .o_data  (w_pipe_dat)
    );

    assign Q_VALID   = w_pipe_vld;
    assign INIT_DONE = r_init_done;

`ifdef SRAM_RANDOMIZE_Q_EN
    localparam int RW = ((DATA_WIDTH + 31) / 32) * 32;

    function automatic logic [DATA_WIDTH-1:0] rand_word();
        logic [RW-1:0] t;
        for (int i = 0; i < RW / 32; i++) begin
            t[i*32 +: 32] = $random;
        end
        return t[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_rand;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = rand_word();
        end
    end

    always_ff @(posedge CLK) begin
        r_rand <= rand_word();
    end

    assign Q = w_pipe_vld ? w_pipe_dat : r_rand;
`else
    assign Q = w_pipe_dat;
`endif

endmodule

// File: tb/tb_sram_sp_bwe_model.sv
// Directed bench for sram_sp_bwe_model: three instances share stimulus
// (L=1/D=128, L=3/D=128, L=2/D=100) and are scored against queues.
module tb_sram_sp_bwe_model;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        CEB;
    logic        WEB;
    logic [6:0]  A;
    logic [63:0] D;
    logic [7:0]  BWEB;

    logic [63:0] q_o [3];
    logic        qv  [3];
    logic        idn [3];

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sbq [3][$];

    logic [63:0] m128 [128];
    logic [63:0] m100 [100];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    sram_sp_bwe_model #(
        .DATA_WIDTH(64), .DEPTH(128), .ADDR_WIDTH(7),
        .SEG_WIDTH(8), .READ_LATENCY(1)
    ) u_a (
        .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D),
        .BWEB(BWEB), .Q(q_o[0]), .Q_VALID(qv[0]), .INIT_DONE(idn[0])
    );

    sram_sp_bwe_model #(
        .DATA_WIDTH(64), .DEPTH(128), .ADDR_WIDTH(7),
        .SEG_WIDTH(8), .READ_LATENCY(3)
    ) u_b (
        .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D),
        .BWEB(BWEB), .Q(q_o[1]), .Q_VALID(qv[1]), .INIT_DONE(idn[1])
    );

    sram_sp_bwe_model #(
        .DATA_WIDTH(64), .DEPTH(100), .ADDR_WIDTH(7),
        .SEG_WIDTH(8), .READ_LATENCY(2)
    ) u_c (
        .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D),
        .BWEB(BWEB), .Q(q_o[2]), .Q_VALID(qv[2]), .INIT_DONE(idn[2])
    );

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each expected read is due in exactly one cycle; any other
    // cycle must show Q_VALID low.
    always @(negedge CLK) begin
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
                    chk($sformatf("rd%0d_valid", i), 64'(qv[i]), 64'd1);
                    chk($sformatf("rd%0d_data", i), q_o[i], sbq[i][0].data);
                    void'(sbq[i].pop_front());
                end else begin
                    chk($sformatf("idle%0d_valid", i), 64'(qv[i]), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CEB  = 1'b1;
        WEB  = 1'b1;
        A    = '0;
        D    = '0;
        BWEB = '1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [63:0] d,
                            input logic [7:0] be, input bit apply);
        CEB  = 1'b0;
        WEB  = 1'b0;
        A    = a;
        D    = d;
        BWEB = be;
        if (apply) begin
            for (int s = 0; s < 8; s++) begin
                if (!be[s]) begin
                    m128[a][s*8 +: 8] = d[s*8 +: 8];
                    if (a < 100) m100[a][s*8 +: 8] = d[s*8 +: 8];
                end
            end
        end
        tick();
        idle();
    endtask

    task automatic do_read(input logic [6:0] a);
        exp_t e;
        CEB  = 1'b0;
        WEB  = 1'b1;
        A    = a;
        D    = {$urandom, $urandom};
        BWEB = 8'($urandom);
        e.data = m128[a];
        e.due  = cyc + 1;
        sbq[0].push_back(e);
        e.due  = cyc + 3;
        sbq[1].push_back(e);
        e.data = (a < 100) ? m100[a] : 64'd0;
        e.due  = cyc + 2;
        sbq[2].push_back(e);
        tick();
        idle();
    endtask

    // Reads still in flight when reset hits are never delivered.
    task automatic raise_rst();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            while (sbq[i].size() > 0 && sbq[i][$].due > cyc) begin
                void'(sbq[i].pop_back());
            end
        end
    endtask

    initial begin
        idle();
        RST = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_q%0d", i), q_o[i], 64'd0);
            chk($sformatf("rst_qv%0d", i), 64'(qv[i]), 64'd0);
            chk($sformatf("rst_done%0d", i), 64'(idn[i]), 64'd0);
        end

        RST = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("sweep1_done%0d", i), 64'(idn[i]), 64'd0);
            end
        end
        raise_rst();
        tick();
        RST = 1'b0;

        for (int k = 1; k <= 130; k++) begin
            if (k == 5) begin
                do_write(7'd7, '1, 8'h00, 1'b0);
            end else begin
                tick();
            end
            chk($sformatf("sweep_done_a_k%0d", k), 64'(idn[0]),
                64'(k >= 128));
            chk($sformatf("sweep_done_b_k%0d", k), 64'(idn[1]),
                64'(k >= 128));
            chk($sformatf("sweep_done_c_k%0d", k), 64'(idn[2]),
                64'(k >= 100));
        end

        for (int a = 0; a < 128; a++) m128[a] = '0;
        for (int a = 0; a < 100; a++) m100[a] = '0;

        for (int a = 0; a < 128; a++) do_read(7'(a));
        repeat (6) tick();

        do_write(7'd5, 64'h1122334455667788, 8'h00, 1'b1);
        do_write(7'd5, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 1'b1);
        do_read(7'd5);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mask_q%0d", i), q_o[i], 64'h11223344FFFFFFFF);
        end

        for (int a = 0; a < 4; a++) do_write(7'(a), 64'(10 + a), 8'h00, 1'b1);
        for (int a = 0; a < 4; a++) do_read(7'(a));
        repeat (6) tick();
        chk("lat3_last_q", q_o[1], 64'd13);

        do_write(7'd110, '1, 8'h00, 1'b1);
        do_read(7'd110);
        for (int a = 0; a < 100; a++) do_read(7'(a));
        repeat (5) tick();

        do_read(7'd5);
        repeat (4) tick();
        do_read(7'd0);
        raise_rst();
        tick();
        chk("midrd_q_b", q_o[1], 64'd0);
        chk("midrd_qv_b", 64'(qv[1]), 64'd0);
        chk("midrd_q_c", q_o[2], 64'd0);
        chk("midrd_qv_c", 64'(qv[2]), 64'd0);
        tick();
        RST = 1'b0;
        repeat (6) tick();
        chk("midrd_q_c_hold", q_o[2], 64'd0);
        chk("midrd_q_a", q_o[0], 64'd0);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_empty%0d", i), 64'(sbq[i].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
